bit_rate_crusher: RTL and testbench
===================================

Name: bit_rate_crusher

Overview:
- Parametrised bit-depth and sample-rate reduction effect for the audio path; successor to the single-mode bit crusher.
- Sits between the sample source and the mixer/DAC feed; one sample in per start pulse, one sample out per done pulse.
- Adds round-to-nearest quantisation with saturation, a sample-and-hold decimator, a busy flag and clamped crush depth.

Parameters:
WIDTH, 12, sample width in bits (signed two's complement), >= 4
CRUSH_W, 3, width of bits_to_crush
HOLD_W, 4, width of hold_factor

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  sample-valid strobe; accepted only when busy=0
enable  input  1  1 = apply effect, 0 = bypass
round_en  input  1  1 = round-to-nearest, 0 = truncate
bits_to_crush  input  CRUSH_W  number of LSBs to zero (k)
hold_factor  input  HOLD_W  decimation factor N; 0 and 1 mean no decimation
incoming_sample  input  WIDTH  signed input sample
modified_sample  output  WIDTH  signed processed sample (registered)
done  output  1  one-cycle pulse, modified_sample valid
busy  output  1  high while a sample is in flight

Behaviour:
- Reset: modified_sample=0, done=0, busy=0, state IDLE, hold counter=0, held value=0. Reset overrides everything, including mid-operation; the aborted sample produces no done.
- States: IDLE, QUANT, OUT. busy = (state != IDLE). done defaults to 0 every cycle and is never high for two consecutive cycles.
- IDLE: on start, latch incoming_sample, enable, round_en, k, hold_factor. Go to QUANT if enable=1, else OUT with bypass flag.
  - start while busy=1 is ignored: no latch, no queued sample.
- Bypass (enable=0 at accept):
  - OUT registers modified_sample = latched sample, done=1, then IDLE.
  - Hold counter is cleared to 0.
- Latency: let E be the clock edge that samples start.
  - Bypass: done and modified_sample are updated at E+2.
  - Enabled: done and modified_sample are updated at E+3.
  - Throughput is one sample per 3 cycles (bypass) or 4 cycles (enabled).
- QUANT (enabled):
  - Effective shift ke = min(k, WIDTH-1).
  - If hold counter == 0: compute a new quantised value q; store q as held value.
  - Otherwise reuse the held value; the input sample is discarded.
  - Counter advances to (cnt+1) mod Neff, where Neff = max(latched hold_factor, 1).
  - If the counter is >= Neff-1 after a hold_factor change, it wraps to 0.
  - Next state OUT.
- Quantisation rules:
  - ke=0: q = x.
  - Truncate: q = (x >>> ke) <<< ke, which floors toward negative infinity.
  - Round: s = x + 2^(ke-1), computed at WIDTH+1 bits, then q = (s >>> ke) <<< ke.
  - If s exceeds the max positive value, saturate to (2^(WIDTH-1)-1) with the low ke bits cleared. Negative values never saturate.
- OUT (enabled): modified_sample = held value, done=1, then IDLE.
- Control inputs are only sampled at start acceptance; changing them mid-operation has no effect on the in-flight sample.

Test Plan:
- Reset, then bypass: enable=0, x=0x5A3 -> modified_sample=0x5A3, done pulses one cycle at E+2, busy high for 2 cycles.
- Truncate, enable=1, round_en=0, N=1:
  - x=0x7FF, k=3 -> 0x7F8.
  - x=-5 (0xFFB), k=2 -> -8 (0xFF8).
  - done at E+3.
- Round, round_en=1:
  - x=13, k=2 -> 12; x=14, k=2 -> 16.
  - x=0x7FF, k=3 -> saturates to 0x7F8.
  - x=-6, k=2 -> -4 (0xFFC).
- Decimation: hold_factor=3, k=0, inputs 100,200,300,400,500 -> outputs 100,100,100,400,400. Then a bypass sample resets the counter, and the next enabled input 7 -> 7.
- Handshake and clamp:
  - start held high continuously -> samples accepted every 4 cycles only; starts during busy are dropped.
  - k=7 with WIDTH=4 -> ke=3.
- Reset at E+1 of an enabled sample -> no done, outputs 0. The next start behaves as the first sample after reset (counter=0).

Source files
------------

// File: rtl/bit_rate_crusher.sv
// Bit-depth and sample-rate reduction for the audio path: quantises (truncate or
// round-to-nearest with saturation) and optionally holds samples for N inputs.
module bit_rate_crusher #(
    parameter int WIDTH   = 12,
    parameter int CRUSH_W = 3,
    parameter int HOLD_W  = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               enable,
    input  logic               round_en,
    input  logic [CRUSH_W-1:0] bits_to_crush,
    input  logic [HOLD_W-1:0]  hold_factor,
    input  logic [WIDTH-1:0]   incoming_sample,
    output logic [WIDTH-1:0]   modified_sample,
    output logic               done,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, QUANT, OUT} state_t;

    state_t             state_q, state_d;
    logic               acc_q, acc_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   held_q, held_d;
    logic [WIDTH-1:0]   mod_q, mod_d;
    logic               en_q, en_d;
    logic               rnd_q, rnd_d;
    logic [CRUSH_W-1:0] k_q, k_d;
    logic [HOLD_W-1:0]  hf_q, hf_d;
    logic [HOLD_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0]  neff_m1;

    function automatic int eff_shift(input logic [CRUSH_W-1:0] k);
        if (int'(k) > WIDTH - 1)
            return WIDTH - 1;
        return int'(k);
    endfunction

    // Rounding adds half an LSB at WIDTH+1 bits so the top positive codes can
    // overflow; those clamp to the largest positive multiple of 2^ke.
    function automatic logic [WIDTH-1:0] quantise(input logic [WIDTH-1:0] x,
                                                  input int ke,
                                                  input logic rnd);
        logic        [WIDTH-1:0] low_mask;
        logic        [WIDTH:0]   half;
        logic signed [WIDTH:0]   s;
        logic signed [WIDTH:0]   max_pos;
        low_mask = ~({WIDTH{1'b1}} << ke);
        max_pos  = $signed({2'b00, {(WIDTH-1){1'b1}}});
        if (!rnd || ke == 0)
            return x & ~low_mask;
        half = {{WIDTH{1'b0}}, 1'b1} << (ke - 1);
        s    = $signed({x[WIDTH-1], x}) + $signed(half);
        if (s > max_pos)
            return max_pos[WIDTH-1:0] & ~low_mask;
        return s[WIDTH-1:0] & ~low_mask;
    endfunction

    assign neff_m1 = (hf_q == '0) ? '0 : hf_q - HOLD_W'(1);

    // An accepted sample spends one cycle in the accept stage (acc_q) before
    // the FSM leaves IDLE, giving E+2 (bypass) / E+3 (enabled) latency.
    always_comb begin
        state_d = state_q;
        acc_d   = 1'b0;
        done_d  = 1'b0;
        x_d     = x_q;
        en_d    = en_q;
        rnd_d   = rnd_q;
        k_d     = k_q;
        hf_d    = hf_q;
        cnt_d   = cnt_q;
        held_d  = held_q;
        mod_d   = mod_q;
        case (state_q)
            IDLE: begin
                if (acc_q) begin
                    state_d = en_q ? QUANT : OUT;
                    if (!en_q)
                        cnt_d = '0;
                end else if (start) begin
                    acc_d = 1'b1;
                    x_d   = incoming_sample;
                    en_d  = enable;
                    rnd_d = round_en;
                    k_d   = bits_to_crush;
                    hf_d  = hold_factor;
                end
            end
            QUANT: begin
                if (cnt_q == '0)
                    held_d = quantise(x_q, eff_shift(k_q), rnd_q);
                cnt_d   = (cnt_q >= neff_m1) ? '0 : cnt_q + HOLD_W'(1);
                state_d = OUT;
            end
            OUT: begin
                mod_d   = en_q ? held_q : x_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            held_q  <= '0;
            mod_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
            mod_q   <= mod_d;
        end
    end

    always_ff @(posedge clock) begin
        x_q   <= x_d;
        en_q  <= en_d;
        rnd_q <= rnd_d;
        k_q   <= k_d;
        hf_q  <= hf_d;
    end

    assign modified_sample = mod_q;
    assign done            = done_q;
    assign busy            = acc_q || (state_q != IDLE);

endmodule

// File: tb/tb_bit_rate_crusher.sv
// Scoreboard bench for bit_rate_crusher: stimulus pushes expected value and due
// cycle; negedge monitors pop and compare whenever done is seen.
module tb_bit_rate_crusher;

    typedef struct {
        logic [11:0] val;
        int          due;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        enable = 1'b0;
    logic        round_en = 1'b0;
    logic [2:0]  bits_to_crush = 3'd0;
    logic [3:0]  hold_factor = 4'd1;
    logic [11:0] incoming_sample = 12'd0;
    logic [11:0] modified_sample;
    logic        done;
    logic        busy;

    logic        s_start = 1'b0;
    logic        s_rnd = 1'b0;
    logic [3:0]  s_x = 4'd0;
    logic [3:0]  s_mod;
    logic        s_done;
    logic        s_busy;

    exp_t sb[$];
    exp_t sb4[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;

    bit_rate_crusher #(.WIDTH(12), .CRUSH_W(3), .HOLD_W(4)) u_dut (
        .clock(clock), .reset(reset), .start(start), .enable(enable),
        .round_en(round_en), .bits_to_crush(bits_to_crush),
        .hold_factor(hold_factor), .incoming_sample(incoming_sample),
        .modified_sample(modified_sample), .done(done), .busy(busy)
    );

    bit_rate_crusher #(.WIDTH(4), .CRUSH_W(3), .HOLD_W(4)) u_small (
        .clock(clock), .reset(reset), .start(s_start), .enable(1'b1),
        .round_en(s_rnd), .bits_to_crush(3'd7), .hold_factor(4'd1),
        .incoming_sample(s_x), .modified_sample(s_mod), .done(s_done),
        .busy(s_busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        exp_t e;
        if (done) begin
            checks++;
            if (prev_done) begin
                errors++;
                $display("FAIL done_consecutive act=1 req=0 at cycle %0d", cyc);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done act=%h req=no_output at cycle %0d", modified_sample, cyc);
            end else begin
                e = sb.pop_front();
                if (modified_sample !== e.val) begin
                    errors++;
                    $display("FAIL sample act=%h req=%h at cycle %0d", modified_sample, e.val, cyc);
                end
                checks++;
                if (cyc != e.due) begin
                    errors++;
                    $display("FAIL latency act=cycle %0d req=cycle %0d", cyc, e.due);
                end
            end
        end
        prev_done = done;
    end

    always @(negedge clock) begin
        exp_t e;
        if (s_done) begin
            checks++;
            if (sb4.size() == 0) begin
                errors++;
                $display("FAIL small_unexpected_done act=%h req=no_output", s_mod);
            end else begin
                e = sb4.pop_front();
                if ({8'd0, s_mod} !== e.val || cyc != e.due) begin
                    errors++;
                    $display("FAIL small_sample act=%h@%0d req=%h@%0d", s_mod, cyc, e.val[3:0], e.due);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s act=%h req=%h", name, act, req);
        end
    endtask

    task automatic wait_idle();
        int waited = 0;
        @(negedge clock);
        while (busy && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout act=busy req=idle");
        end
    endtask

    task automatic send(input logic en, input logic rnd, input logic [2:0] k,
                        input logic [3:0] hf, input logic [11:0] x,
                        input logic [11:0] expv, input bit push);
        wait_idle();
        enable          = en;
        round_en        = rnd;
        bits_to_crush   = k;
        hold_factor     = hf;
        incoming_sample = x;
        start           = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        if (push)
            sb.push_back('{expv, cyc + (en ? 3 : 2)});
    endtask

    task automatic send_small(input logic rnd, input logic [3:0] x, input logic [3:0] expv);
        @(negedge clock);
        s_rnd   = rnd;
        s_x     = x;
        s_start = 1'b1;
        @(posedge clock);
        #1;
        s_start = 1'b0;
        sb4.push_back('{{8'd0, expv}, cyc + 3});
        repeat (4) @(negedge clock);
    endtask

    initial begin
        int w;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("reset_sample", modified_sample, 12'h000);
        chk("reset_done", {11'd0, done}, 12'h000);
        chk("reset_busy", {11'd0, busy}, 12'h000);

        send(1'b0, 1'b0, 3'd0, 4'd1, 12'h5A3, 12'h5A3, 1'b1);
        @(negedge clock);
        chk("bypass_busy_e0", {11'd0, busy}, 12'h001);
        @(negedge clock);
        chk("bypass_busy_e1", {11'd0, busy}, 12'h001);
        @(negedge clock);
        chk("bypass_busy_e2", {11'd0, busy}, 12'h000);

        send(1'b1, 1'b0, 3'd3, 4'd1, 12'h7FF, 12'h7F8, 1'b1);
        send(1'b1, 1'b0, 3'd2, 4'd1, 12'hFFB, 12'hFF8, 1'b1);

        send(1'b1, 1'b1, 3'd2, 4'd1, 12'd13, 12'd12, 1'b1);
        send(1'b1, 1'b1, 3'd2, 4'd1, 12'd14, 12'd16, 1'b1);
        send(1'b1, 1'b1, 3'd3, 4'd1, 12'h7FF, 12'h7F8, 1'b1);
        send(1'b1, 1'b1, 3'd2, 4'd1, 12'hFFA, 12'hFFC, 1'b1);
        send(1'b1, 1'b1, 3'd2, 4'd1, 12'hFFB, 12'hFFC, 1'b1);
        send(1'b1, 1'b1, 3'd3, 4'd1, 12'h800, 12'h800, 1'b1);

        send(1'b1, 1'b0, 3'd0, 4'd3, 12'd100, 12'd100, 1'b1);
        send(1'b1, 1'b0, 3'd0, 4'd3, 12'd200, 12'd100, 1'b1);
        send(1'b1, 1'b0, 3'd0, 4'd3, 12'd300, 12'd100, 1'b1);
        send(1'b1, 1'b0, 3'd0, 4'd3, 12'd400, 12'd400, 1'b1);
        send(1'b1, 1'b0, 3'd0, 4'd3, 12'd500, 12'd400, 1'b1);
        send(1'b0, 1'b0, 3'd0, 4'd3, 12'd55, 12'd55, 1'b1);
        send(1'b1, 1'b0, 3'd0, 4'd3, 12'd7, 12'd7, 1'b1);
        send(1'b1, 1'b0, 3'd0, 4'd1, 12'd9, 12'd7, 1'b1);
        send(1'b1, 1'b0, 3'd0, 4'd1, 12'd9, 12'd9, 1'b1);

        send(1'b1, 1'b0, 3'd3, 4'd1, 12'h7FF, 12'h7F8, 1'b1);
        enable          = 1'b0;
        bits_to_crush   = 3'd0;
        round_en        = 1'b1;
        hold_factor     = 4'd5;
        incoming_sample = 12'd0;

        wait_idle();
        enable          = 1'b1;
        round_en        = 1'b0;
        bits_to_crush   = 3'd0;
        hold_factor     = 4'd1;
        incoming_sample = 12'd10;
        start           = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock);
            #1;
            if (i % 4 == 0)
                sb.push_back('{incoming_sample, cyc + 3});
            if (i == 11) begin
                start = 1'b0;
            end else begin
                @(negedge clock);
                incoming_sample = 12'(10 * (i + 2));
            end
        end

        send(1'b1, 1'b0, 3'd0, 4'd3, 12'd33, 12'd33, 1'b1);
        send(1'b1, 1'b0, 3'd0, 4'd1, 12'd300, 12'd0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("abort_sample", modified_sample, 12'h000);
        chk("abort_busy", {11'd0, busy}, 12'h000);
        send(1'b1, 1'b0, 3'd0, 4'd3, 12'd77, 12'd77, 1'b1);

        send_small(1'b0, 4'hD, 4'h8);
        send_small(1'b1, 4'hB, 4'h8);

        w = 0;
        while ((sb.size() != 0 || sb4.size() != 0) && w < 100) begin
            @(negedge clock);
            w++;
        end
        checks++;
        if (sb.size() != 0 || sb4.size() != 0) begin
            errors++;
            $display("FAIL drain act=%0d pending req=0 pending", sb.size() + sb4.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
